// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mdu_ctrl
// Description : E-stage multiply/divide sequencer. Computes the result at
//               issue, holds it in a pending register for a fixed latency,
//               then commits it to architectural HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [2:0]  i_md_op,
    input  logic        i_flush,
    input  logic [31:0] i_rs_val,
    input  logic [31:0] i_rt_val,
    output logic        o_busy,
    output logic        o_md_hazard,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_RUN   = 1'b1;

    localparam logic [2:0] c_OP_MULT  = 3'd1;
    localparam logic [2:0] c_OP_MULTU = 3'd2;
    localparam logic [2:0] c_OP_DIV   = 3'd3;
    localparam logic [2:0] c_OP_DIVU  = 3'd4;
    localparam logic [2:0] c_OP_MTHI  = 3'd5;
    localparam logic [2:0] c_OP_MTLO  = 3'd6;

    localparam logic [3:0] c_MULT_LAT = 4'(MULT_CYCLES);
    localparam logic [3:0] c_DIV_LAT  = 4'(DIV_CYCLES);

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [63:0] r_pend;
    logic        r_pend_ok;

    logic        w_accept;
    logic        w_op_is_md;
    logic        w_op_is_mult;
    logic        w_op_is_div;
    logic        w_load_md;
    logic        w_busy;
    logic        w_commit;

    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic        w_div_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [63:0] w_result;
    logic        w_result_ok;

    assign w_op_is_mult = (i_md_op == c_OP_MULT) || (i_md_op == c_OP_MULTU);
    assign w_op_is_div  = (i_md_op == c_OP_DIV)  || (i_md_op == c_OP_DIVU);
    assign w_op_is_md   = w_op_is_mult || w_op_is_div;
    assign w_accept     = i_start && !i_flush && (r_state == c_ST_IDLE);
    assign w_load_md    = w_accept && w_op_is_md;

    // ------------------------------------------------------------------------
    // Arithmetic, evaluated in the issue cycle only
    // ------------------------------------------------------------------------
    assign w_prod_s = $signed({{32{i_rs_val[31]}}, i_rs_val})
                    * $signed({{32{i_rt_val[31]}}, i_rt_val});
    assign w_prod_u = {32'd0, i_rs_val} * {32'd0, i_rt_val};

    // Signed divide done on magnitudes so MIN_INT / -1 wraps to MIN_INT, rem 0.
    assign w_div_signed = (i_md_op == c_OP_DIV);
    assign w_a_neg      = w_div_signed && i_rs_val[31];
    assign w_b_neg      = w_div_signed && i_rt_val[31];
    assign w_a_mag      = w_a_neg ? (32'd0 - i_rs_val) : i_rs_val;
    assign w_b_mag      = (i_rt_val == 32'd0) ? 32'd1 :
                          (w_b_neg ? (32'd0 - i_rt_val) : i_rt_val);
    assign w_q_mag      = w_a_mag / w_b_mag;
    assign w_r_mag      = w_a_mag % w_b_mag;
    assign w_quot       = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem        = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    always_comb begin
        w_result    = 64'd0;
        w_result_ok = 1'b1;
        case (i_md_op)
            c_OP_MULT:  w_result = w_prod_s;
            c_OP_MULTU: w_result = w_prod_u;
            c_OP_DIV,
            c_OP_DIVU: begin
                w_result    = {w_rem, w_quot};
                w_result_ok = (i_rt_val != 32'd0);
            end
            default:    w_result = 64'd0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_ST_IDLE: begin
                if (w_load_md) begin
                    w_state_nxt = c_ST_RUN;
                    w_cnt_nxt   = w_op_is_mult ? c_MULT_LAT : c_DIV_LAT;
                end
            end
            c_ST_RUN: begin
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_comb begin
        w_busy   = (r_state == c_ST_RUN);
        w_commit = (r_state == c_ST_RUN) && (r_cnt <= 4'd1);
    end

    // ------------------------------------------------------------------------
    // Pending result and architectural HI/LO
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend    <= 64'd0;
            r_pend_ok <= 1'b0;
        end else if (w_load_md) begin
            r_pend    <= w_result;
            r_pend_ok <= w_result_ok;
        end
    end

    // Commit and MTHI/MTLO are exclusive: moves are only accepted in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_hi <= 32'd0;
            o_lo <= 32'd0;
        end else if (w_commit) begin
            if (r_pend_ok) begin
                o_hi <= r_pend[63:32];
                o_lo <= r_pend[31:0];
            end
        end else if (w_accept) begin
            if (i_md_op == c_OP_MTHI) begin
                o_hi <= i_rs_val;
            end
            if (i_md_op == c_OP_MTLO) begin
                o_lo <= i_rs_val;
            end
        end
    end

    assign o_busy      = w_busy;
    assign o_md_hazard = w_busy || (i_start && !i_flush && w_op_is_md);

endmodule
`default_nettype wire

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide sequencer for the E-stage of the pipelined MIPS core.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E-stage and holds operands internally.
- Counts out a fixed latency, then commits results to architectural HI/LO.
- Drives the busy indication the hazard unit uses to stall later HI/LO-dependent instructions.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  valid MD-class instruction in E-stage this cycle
- md_op  input  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP)
- flush  input  1  E-stage instruction is being killed (exception/interrupt); gates start
- rs_val  input  32  forwarded rs operand
- rt_val  input  32  forwarded rt operand
- busy  output  1  registered; high while an operation is in flight
- md_hazard  output  1  combinational: busy OR (start AND NOT flush AND md_op in 1..4)
- hi  output  32  architectural HI register
- lo  output  32  architectural LO register

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. While reset is low: state=IDLE, counter=0, busy=0, hi=0, lo=0, pending result=0. Reset mid-operation abandons the operation; HI/LO stay 0.
- Accept condition: start & ~flush & state==IDLE. With flush=1 the instruction has no effect at all.
- States: IDLE, RUN.
- IDLE, accepted op 1..4:
  - Compute {res_hi,res_lo} and latch it into a pending register.
  - Load counter with MULT_CYCLES or DIV_CYCLES, go to RUN; busy=1 from the next cycle.
- IDLE, accepted MTHI: hi<=rs_val at that edge; stay in IDLE, busy stays 0.
- IDLE, accepted MTLO: lo<=rs_val at that edge; stay in IDLE, busy stays 0.
- IDLE, NOP/7: no effect.
- RUN:
  - Counter decrements each edge.
  - At the edge where the counter goes 1->0: hi/lo<=pending, state<=IDLE, busy<=0.
  - Timing: op accepted at edge k -> busy high during cycles k..k+N-1 -> hi/lo visible after edge k+N.
- start while in RUN (any op, including MTHI/MTLO) is ignored; the hazard unit must stall, and the verification bench flags it as a protocol error.
- flush during RUN does not cancel the in-flight op (it belongs to an already-committed instruction).
- Arithmetic:
  - MULT: signed 32x32->64, hi=upper, lo=lower.
  - MULTU: unsigned 32x32->64, hi=upper, lo=lower.
  - DIV: signed; lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - DIV overflow case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - DIVU: unsigned; lo=quotient, hi=remainder.
  - Divide by zero (DIV/DIVU): the op still occupies DIV_CYCLES, but hi/lo are left unchanged at completion.
- Outputs hi/lo always reflect the committed values. The pending result is never visible early.

Test Plan:
- Reset low, then release -> busy=0, hi=0, lo=0. MULT rs=0xFFFFFFFE (-2), rt=3 -> busy=1 for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001. md_hazard=1 combinationally in the start cycle.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x1234 then MTLO 0x5678 on consecutive cycles -> hi=0x1234 and lo=0x5678 each one edge later; busy stays 0. Then DIVU rt=0 -> busy 10 cycles, hi/lo unchanged.
- start=1, md_op=MULT, flush=1 -> busy stays 0, md_hazard=0, hi/lo unchanged. Flush pulse at RUN cycle 2 of a MULT -> result still committed at cycle 5.
- Assert reset at RUN cycle 3 of a DIV -> busy, hi and lo go to 0 immediately (asynchronously); after release, no late commit occurs.
